// File: rtl/matmul_tile_controller.sv
// Sequencer for one C = A x B tile: walks (m, n, k), issues BRAM reads for A and B,
// waits for the PE accumulation of each C element, then writes it out with a valid/ready handshake.
module matmul_tile_controller #(
    parameter int M_MAX    = 8,
    parameter int K_MAX    = 8,
    parameter int N_MAX    = 8,
    parameter int BRAM_LAT = 1,
    localparam int MW = $clog2(M_MAX + 1),
    localparam int KW = $clog2(K_MAX + 1),
    localparam int NW = $clog2(N_MAX + 1),
    localparam int AW = $clog2(M_MAX * K_MAX),
    localparam int BW = $clog2(K_MAX * N_MAX),
    localparam int CW = $clog2(M_MAX * N_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [MW-1:0] m_cfg_i,
    input  logic [KW-1:0] k_cfg_i,
    input  logic [NW-1:0] n_cfg_i,
    input  logic          pe_res_valid_i,
    input  logic          c_ready_i,
    output logic          rd_en_o,
    output logic [AW-1:0] a_addr_o,
    output logic [BW-1:0] b_addr_o,
    output logic          pe_valid_o,
    output logic          pe_first_o,
    output logic          pe_last_o,
    output logic          c_valid_o,
    output logic [CW-1:0] c_addr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          cfg_err_o,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t        state_q;
    logic [MW-1:0] m_q, mc_q;
    logic [KW-1:0] k_q, kc_q;
    logic [NW-1:0] n_q, nc_q;
    logic          rd_en_q, c_valid_q, done_q, cfg_err_q;
    logic [AW-1:0] a_addr_q;
    logic [BW-1:0] b_addr_q;
    logic [CW-1:0] c_addr_q;
    logic [BRAM_LAT-1:0] pv_q, pf_q, pl_q;

    logic          cfg_ok_d, k_last_d, n_last_d, last_elem_d, flush_d;
    logic [KW-1:0] k_inc_d;
    logic [MW-1:0] m_adv_d;
    logic [NW-1:0] n_adv_d;
    logic [AW-1:0] a_next_d, a_elem_d;
    logic [BW-1:0] b_next_d, b_elem_d;
    logic [CW-1:0] c_cur_d;

    // Address products are formed in 32-bit int and truncated; legal dimensions always fit.
    always_comb begin
        cfg_ok_d    = (m_cfg_i != '0) && (m_cfg_i <= MW'(M_MAX)) &&
                      (k_cfg_i != '0) && (k_cfg_i <= KW'(K_MAX)) &&
                      (n_cfg_i != '0) && (n_cfg_i <= NW'(N_MAX));
        k_last_d    = (k_q == kc_q - KW'(1));
        n_last_d    = (n_q == nc_q - NW'(1));
        last_elem_d = n_last_d && (m_q == mc_q - MW'(1));
        flush_d     = abort_i && (state_q != IDLE);
        k_inc_d     = k_q + KW'(1);
        n_adv_d     = n_last_d ? '0 : n_q + NW'(1);
        m_adv_d     = n_last_d ? m_q + MW'(1) : m_q;
        a_next_d    = AW'(int'(m_q) * int'(kc_q) + int'(k_inc_d));
        b_next_d    = BW'(int'(k_inc_d) * int'(nc_q) + int'(n_q));
        a_elem_d    = AW'(int'(m_adv_d) * int'(kc_q));
        b_elem_d    = BW'(int'(n_adv_d));
        c_cur_d     = CW'(int'(m_q) * int'(nc_q) + int'(n_q));
    end

    // C handshake: c_valid/c_addr stay fixed until the edge where c_valid && c_ready, which is the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            mc_q      <= '0;
            kc_q      <= '0;
            nc_q      <= '0;
            rd_en_q   <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_valid_q <= 1'b0;
            c_addr_q  <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (flush_d) begin
                state_q   <= IDLE;
                rd_en_q   <= 1'b0;
                c_valid_q <= 1'b0;
                done_q    <= 1'b0;
                m_q       <= '0;
                n_q       <= '0;
                k_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (cfg_ok_d) begin
                                mc_q     <= m_cfg_i;
                                kc_q     <= k_cfg_i;
                                nc_q     <= n_cfg_i;
                                m_q      <= '0;
                                n_q      <= '0;
                                k_q      <= '0;
                                rd_en_q  <= 1'b1;
                                a_addr_q <= '0;
                                b_addr_q <= '0;
                                state_q  <= ISSUE;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (k_last_d) begin
                            k_q     <= '0;
                            rd_en_q <= 1'b0;
                            state_q <= WAIT;
                        end else begin
                            k_q      <= k_inc_d;
                            a_addr_q <= a_next_d;
                            b_addr_q <= b_next_d;
                        end
                    end
                    WAIT: begin
                        if (pe_res_valid_i) begin
                            c_valid_q <= 1'b1;
                            c_addr_q  <= c_cur_d;
                            state_q   <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (c_ready_i) begin
                            c_valid_q <= 1'b0;
                            n_q       <= n_adv_d;
                            m_q       <= m_adv_d;
                            if (last_elem_d) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                rd_en_q  <= 1'b1;
                                a_addr_q <= a_elem_d;
                                b_addr_q <= b_elem_d;
                                state_q  <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Operand flags travel alongside rd_en so they reach the PE with the BRAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else if (flush_d) begin
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q <= (pv_q << 1) | BRAM_LAT'(rd_en_q);
            pf_q <= (pf_q << 1) | BRAM_LAT'(rd_en_q && (k_q == '0));
            pl_q <= (pl_q << 1) | BRAM_LAT'(rd_en_q && k_last_d);
        end
    end

    assign rd_en_o    = rd_en_q;
    assign a_addr_o   = a_addr_q;
    assign b_addr_o   = b_addr_q;
    assign pe_valid_o = pv_q[BRAM_LAT-1];
    assign pe_first_o = pf_q[BRAM_LAT-1];
    assign pe_last_o  = pl_q[BRAM_LAT-1];
    assign c_valid_o  = c_valid_q;
    assign c_addr_o   = c_addr_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign cfg_err_o  = cfg_err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_matmul_tile_controller.sv
// Bench for matmul_tile_controller: a job-level model (read/write address queues plus a
// latency line for the PE flags) is compared against the DUT every cycle.
module tb_matmul_tile_controller;

    localparam int M_MAX = 8;
    localparam int K_MAX = 8;
    localparam int N_MAX = 8;
    localparam int LAT   = 1;
    localparam int MW = $clog2(M_MAX + 1);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int NW = $clog2(N_MAX + 1);
    localparam int AW = $clog2(M_MAX * K_MAX);
    localparam int BW = $clog2(K_MAX * N_MAX);
    localparam int CW = $clog2(M_MAX * N_MAX);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start, abort, pe_res_valid, c_ready;
    logic [MW-1:0] m_cfg;
    logic [KW-1:0] k_cfg;
    logic [NW-1:0] n_cfg;
    logic          rd_en, pe_valid, pe_first, pe_last, c_valid, busy, done, cfg_err;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] b_addr;
    logic [CW-1:0] c_addr;
    logic [2:0]    state;

    matmul_tile_controller #(.M_MAX(M_MAX), .K_MAX(K_MAX), .N_MAX(N_MAX), .BRAM_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .m_cfg_i(m_cfg), .k_cfg_i(k_cfg), .n_cfg_i(n_cfg),
        .pe_res_valid_i(pe_res_valid), .c_ready_i(c_ready),
        .rd_en_o(rd_en), .a_addr_o(a_addr), .b_addr_o(b_addr),
        .pe_valid_o(pe_valid), .pe_first_o(pe_first), .pe_last_o(pe_last),
        .c_valid_o(c_valid), .c_addr_o(c_addr), .busy_o(busy), .done_o(done),
        .cfg_err_o(cfg_err), .state_o(state)
    );

    // Second instance with a 3-cycle BRAM latency.
    logic          t3_start, t3_pe_res_valid;
    logic [MW-1:0] t3_m;
    logic [KW-1:0] t3_k;
    logic [NW-1:0] t3_n;
    logic          x3_rd_en, x3_pe_valid, x3_pe_first, x3_pe_last, x3_c_valid, x3_busy, x3_done, x3_cfg_err;
    logic [AW-1:0] x3_a_addr;
    logic [BW-1:0] x3_b_addr;
    logic [CW-1:0] x3_c_addr;
    logic [2:0]    x3_state;

    matmul_tile_controller #(.M_MAX(M_MAX), .K_MAX(K_MAX), .N_MAX(N_MAX), .BRAM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(t3_start), .abort_i(1'b0),
        .m_cfg_i(t3_m), .k_cfg_i(t3_k), .n_cfg_i(t3_n),
        .pe_res_valid_i(t3_pe_res_valid), .c_ready_i(1'b1),
        .rd_en_o(x3_rd_en), .a_addr_o(x3_a_addr), .b_addr_o(x3_b_addr),
        .pe_valid_o(x3_pe_valid), .pe_first_o(x3_pe_first), .pe_last_o(x3_pe_last),
        .c_valid_o(x3_c_valid), .c_addr_o(x3_c_addr), .busy_o(x3_busy), .done_o(x3_done),
        .cfg_err_o(x3_cfg_err), .state_o(x3_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW+BW+1:0] exp_rd_q[$];
    logic [CW-1:0]    exp_c_q[$];
    bit mdl_busy, mdl_wait, mdl_write, mdl_done, mdl_cfg_err;
    int mdl_issue_left, mdl_k;
    bit [LAT-1:0] pipe_v, pipe_f, pipe_l;

    function automatic void model_clear();
        exp_rd_q.delete();
        exp_c_q.delete();
        mdl_busy = 0; mdl_wait = 0; mdl_write = 0; mdl_done = 0; mdl_cfg_err = 0;
        mdl_issue_left = 0; mdl_k = 0;
        pipe_v = '0; pipe_f = '0; pipe_l = '0;
    endfunction

    function automatic void build_job(input int m, input int k, input int n);
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++) begin
                for (int ki = 0; ki < k; ki++)
                    exp_rd_q.push_back({AW'(mi * k + ki), BW'(ki * n + ni), ki == 0, ki == k - 1});
                exp_c_q.push_back(CW'(mi * n + ni));
            end
    endfunction

    function automatic void model_edge();
        bit in_v, in_f, in_l;
        logic [AW+BW+1:0] e;
        int mi, ki, ni;
        if (!rst_n) begin
            model_clear();
            return;
        end
        in_v = (mdl_issue_left > 0);
        in_f = 0;
        in_l = 0;
        if (in_v) begin
            e = exp_rd_q[0];
            in_f = e[1];
            in_l = e[0];
        end
        mdl_cfg_err = 0;
        if (abort && mdl_busy) begin
            model_clear();
            return;
        end
        pipe_v = (pipe_v << 1) | LAT'(in_v);
        pipe_f = (pipe_f << 1) | LAT'(in_f);
        pipe_l = (pipe_l << 1) | LAT'(in_l);
        if (!mdl_busy) begin
            if (start) begin
                mi = int'(m_cfg); ki = int'(k_cfg); ni = int'(n_cfg);
                if (mi >= 1 && mi <= M_MAX && ki >= 1 && ki <= K_MAX && ni >= 1 && ni <= N_MAX) begin
                    build_job(mi, ki, ni);
                    mdl_busy = 1;
                    mdl_k = ki;
                    mdl_issue_left = ki;
                end else begin
                    mdl_cfg_err = 1;
                end
            end
        end else if (mdl_done) begin
            mdl_done = 0;
            mdl_busy = 0;
        end else if (mdl_issue_left > 0) begin
            void'(exp_rd_q.pop_front());
            mdl_issue_left--;
            if (mdl_issue_left == 0) mdl_wait = 1;
        end else if (mdl_wait) begin
            if (pe_res_valid) begin
                mdl_wait = 0;
                mdl_write = 1;
            end
        end else if (mdl_write && c_ready) begin
            void'(exp_c_q.pop_front());
            mdl_write = 0;
            if (exp_c_q.size() == 0) mdl_done = 1;
            else mdl_issue_left = mdl_k;
        end
    endfunction

    // ---------------- compare + logs ----------------
    int rd_a_log[$], rd_b_log[$], c_log[$];
    int done_cnt, cfg_err_cnt, busy_cnt, cv0_cnt, rd_while_cv, pe_seen, cv_seen;
    bit prev_cv;

    task automatic check_outputs();
        logic [AW+BW+1:0] e;
        chk("rd_en", rd_en, mdl_issue_left > 0);
        if (mdl_issue_left > 0) begin
            e = exp_rd_q[0];
            chk("a_addr", a_addr, e[AW+BW+1:BW+2]);
            chk("b_addr", b_addr, e[BW+1:2]);
        end
        chk("pe_valid", pe_valid, pipe_v[LAT-1]);
        chk("pe_first", pe_first, pipe_f[LAT-1]);
        chk("pe_last", pe_last, pipe_l[LAT-1]);
        chk("c_valid", c_valid, mdl_write);
        if (mdl_write) chk("c_addr", c_addr, exp_c_q[0]);
        chk("busy", busy, mdl_busy);
        chk("done", done, mdl_done);
        chk("cfg_err", cfg_err, mdl_cfg_err);
        if (rd_en) begin
            rd_a_log.push_back(int'(a_addr));
            rd_b_log.push_back(int'(b_addr));
        end
        if (c_valid && !prev_cv) c_log.push_back(int'(c_addr));
        prev_cv = c_valid;
        done_cnt += int'(done);
        cfg_err_cnt += int'(cfg_err);
        busy_cnt += int'(busy);
        pe_seen += int'(pe_valid);
        cv_seen += int'(c_valid);
        if (c_valid && c_addr == '0) cv0_cnt++;
        if (c_valid && rd_en) rd_while_cv++;
    endtask

    task automatic clear_logs();
        rd_a_log.delete(); rd_b_log.delete(); c_log.delete();
        done_cnt = 0; cfg_err_cnt = 0; busy_cnt = 0; cv0_cnt = 0;
        rd_while_cv = 0; pe_seen = 0; cv_seen = 0;
    endtask

    // ---------------- driver ----------------
    int pe_cnt, pe_delay, rdy_mode, stall_left;
    bit noise_en;

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (pe_cnt > 0) pe_cnt--;
        if (pe_last) pe_cnt = pe_delay;
        if (!rst_n) pe_cnt = 0;
        pe_res_valid = (pe_cnt == 1) || (noise_en && !mdl_wait && $urandom_range(0, 7) == 0);
        case (rdy_mode)
            0: c_ready = 1'b1;
            1: c_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (c_valid && stall_left > 0) begin
                    c_ready = 1'b0;
                    stall_left--;
                end else begin
                    c_ready = 1'b1;
                end
            end
        endcase
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (mdl_busy && c < bound) begin
            step();
            c++;
        end
        chk("job_end_busy", busy, 0);
    endtask

    task automatic run_job(input int m, input int k, input int n);
        m_cfg = MW'(m); k_cfg = KW'(k); n_cfg = NW'(n);
        start = 1'b1;
        step();
        wait_idle(5000);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_a_addr"}, a_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_pe_valid"}, pe_valid, 0);
        chk({tag, "_pe_first"}, pe_first, 0);
        chk({tag, "_pe_last"}, pe_last, 0);
        chk({tag, "_c_valid"}, c_valid, 0);
        chk({tag, "_c_addr"}, c_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // 2x2x2 job with literal address tables.
    task automatic check_2x2(input string tag);
        int lit_a[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int lit_b[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
        clear_logs();
        run_job(2, 2, 2);
        chk({tag, "_nreads"}, rd_a_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < rd_a_log.size()) begin
                chk({tag, "_a_lit"}, rd_a_log[i], lit_a[i]);
                chk({tag, "_b_lit"}, rd_b_log[i], lit_b[i]);
            end
        chk({tag, "_nwrites"}, c_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < c_log.size()) chk({tag, "_c_lit"}, c_log[i], i);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, first_rd, pv_first_cyc, pv_last_cyc, pv_cnt, rd3_cnt, done3_cnt, f3_cyc, l3_cyc, cnt3;
        int m, k, n, sel;
        model_clear();
        start = 0; abort = 0; pe_res_valid = 0; c_ready = 1;
        m_cfg = '0; k_cfg = '0; n_cfg = '0;
        t3_start = 0; t3_pe_res_valid = 0; t3_m = '0; t3_k = '0; t3_n = '0;
        pe_cnt = 0; pe_delay = 2; rdy_mode = 0; stall_left = 0; noise_en = 0; prev_cv = 0;
        clear_logs();

        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // Nominal 2x2x2 job, PE answers 2 cycles after pe_last, c_ready tied high.
        check_2x2("j222");

        // First write stalled 5 cycles.
        rdy_mode = 2; stall_left = 5;
        clear_logs();
        run_job(2, 2, 2);
        chk("stall_cv0_cycles", cv0_cnt, 6);
        chk("stall_no_issue", rd_while_cv, 0);
        chk("stall_done_cnt", done_cnt, 1);
        rdy_mode = 0;

        // Illegal configurations.
        clear_logs();
        m_cfg = 2; k_cfg = 0; n_cfg = 2; start = 1'b1;
        repeat (4) step();
        chk("cfgerr_k0_pulses", cfg_err_cnt, 1);
        chk("cfgerr_k0_busy", busy_cnt, 0);
        clear_logs();
        m_cfg = 2; k_cfg = 2; n_cfg = NW'(N_MAX + 1); start = 1'b1;
        repeat (4) step();
        chk("cfgerr_nmax_pulses", cfg_err_cnt, 1);
        chk("cfgerr_nmax_busy", busy_cnt, 0);

        // Abort in the WAIT phase of the second element.
        m_cfg = 2; k_cfg = 2; n_cfg = 2; start = 1'b1;
        step();
        c = 0;
        while (!(mdl_wait && exp_c_q.size() == 3) && c < 200) begin
            step();
            c++;
        end
        chk("abort_wait_reached", int'(c < 200), 1);
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        clear_logs();
        repeat (10) step();
        chk("abort_no_cvalid", cv_seen, 0);
        chk("abort_no_done", done_cnt, 0);
        check_2x2("after_abort");

        // Degenerate shapes.
        clear_logs();
        run_job(1, 1, 1);
        chk("j111_reads", rd_a_log.size(), 1);
        chk("j111_writes", c_log.size(), 1);
        chk("j111_done", done_cnt, 1);
        clear_logs();
        run_job(3, 1, 2);
        chk("j312_reads", rd_a_log.size(), 6);

        // Full-size job with random back-pressure.
        rdy_mode = 1;
        run_job(M_MAX, K_MAX, N_MAX);

        // Reset pulled mid-ISSUE.
        rdy_mode = 0;
        m_cfg = 1; k_cfg = 4; n_cfg = 1; start = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
        repeat (10) step();
        chk("midrst_no_pe_valid", pe_seen, 0);
        chk("midrst_busy", busy_cnt, 0);
        run_job(2, 3, 2);

        // Randomized jobs: random dims, back-pressure, PE delay, start noise, aborts.
        rdy_mode = 1;
        noise_en = 1;
        for (int j = 0; j < 40; j++) begin
            pe_delay = $urandom_range(1, 4);
            m = $urandom_range(1, 4); k = $urandom_range(1, 4); n = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 2);
                if (sel == 0) m = ($urandom_range(0, 1) == 0) ? 0 : M_MAX + 1;
                else if (sel == 1) k = ($urandom_range(0, 1) == 0) ? 0 : K_MAX + 1;
                else n = ($urandom_range(0, 1) == 0) ? 0 : N_MAX + 1;
            end
            m_cfg = MW'(m); k_cfg = KW'(k); n_cfg = NW'(n); start = 1'b1;
            step();
            c = 0;
            while (mdl_busy && c < 3000) begin
                if ($urandom_range(0, 9) == 0) begin
                    m_cfg = MW'($urandom_range(0, 15));
                    k_cfg = KW'($urandom_range(0, 15));
                    n_cfg = NW'($urandom_range(0, 15));
                    start = 1'b1;
                end
                if ($urandom_range(0, 299) == 0) abort = 1'b1;
                step();
                c++;
            end
            chk("rand_job_end", busy, 0);
            repeat ($urandom_range(0, 3)) step();
        end
        noise_en = 0;
        rdy_mode = 0;
        pe_delay = 2;

        // BRAM_LAT=3 instance, k=4.
        t3_m = 1; t3_k = 4; t3_n = 1; t3_start = 1'b1;
        first_rd = -1; pv_first_cyc = -1; pv_last_cyc = -1; pv_cnt = 0;
        rd3_cnt = 0; done3_cnt = 0; f3_cyc = -1; l3_cyc = -1; cnt3 = 0;
        for (int cy = 0; cy < 40; cy++) begin
            @(posedge clk);
            #1;
            t3_start = 1'b0;
            if (x3_rd_en) begin
                rd3_cnt++;
                if (first_rd < 0) first_rd = cy;
            end
            if (x3_pe_valid) begin
                pv_cnt++;
                if (pv_first_cyc < 0) pv_first_cyc = cy;
                pv_last_cyc = cy;
            end
            if (x3_pe_first) f3_cyc = cy;
            if (x3_pe_last) l3_cyc = cy;
            done3_cnt += int'(x3_done);
            if (cnt3 > 0) cnt3--;
            if (x3_pe_last) cnt3 = 2;
            t3_pe_res_valid = (cnt3 == 1);
        end
        chk("lat3_first_rd", first_rd, 0);
        chk("lat3_rd_cycles", rd3_cnt, 4);
        chk("lat3_pv_cycles", pv_cnt, 4);
        chk("lat3_pv_start", pv_first_cyc, first_rd + 3);
        chk("lat3_pv_end", pv_last_cyc, first_rd + 6);
        chk("lat3_first_cyc", f3_cyc, first_rd + 3);
        chk("lat3_last_cyc", l3_cyc, first_rd + 6);
        chk("lat3_done", done3_cnt, 1);
        chk("lat3_idle", x3_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
